trisc_ram_arbiter: RTL and testbench
====================================

TRISC_RAM_ARBITER -- requirements
Module: trisc_ram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to the clock.
REQ-002 SysClock  input  1  system clock; all state updates on its rising edge.
REQ-003 Start  input  1  reset, asynchronous, active-low.
REQ-004 Mode  input  1  0 = run (CPU priority), 1 = load (loader priority).
REQ-005 ClearAddGen  input  1  synchronous clear of the loader address counter.
REQ-006 CpuReq  input  1  CPU access request, level.
REQ-007 CpuWe  input  1  CPU write (1) / read (0).
REQ-008 CpuAddr  input  4  CPU RAM address.
REQ-009 CpuWData  input  8  CPU write data.
REQ-010 LdReq  input  1  loader access request, level.
REQ-011 LdWe  input  1  loader write (1) / read (0).
REQ-012 LdWData  input  8  loader write data.
REQ-013 RamQ  input  8  RAM read data, valid one cycle after address is presented.
REQ-014 RamAddr  output  4  RAM address.
REQ-015 RamData  output  8  RAM write data.
REQ-016 RamWren  output  1  RAM write enable.
REQ-017 RdData  output  8  captured read data, shared by both requesters.
REQ-018 CpuAck  output  1  one-cycle completion pulse for CPU.
REQ-019 LdAck  output  1  one-cycle completion pulse for loader.
REQ-020 LdErr  output  1  one-cycle pulse: loader write rejected.
REQ-021 LdAddr  output  4  current loader address.
REQ-022 Busy  output  1  high in any state other than IDLE.

Function
REQ-023 FSM states SHALL be IDLE, CPU_ISSUE, CPU_CAP, LD_ISSUE, LD_CAP; every access SHALL take exactly ISSUE then CAP (2 cycles), then return to IDLE.
REQ-024 Arbitration SHALL occur only in IDLE; an access in flight SHALL always complete regardless of Mode or request changes.
REQ-025 Mode=0: CpuReq wins; a loader request SHALL be granted only when CpuReq=0 or the starvation rule fires.
REQ-026 Mode=1: LdReq wins; CpuReq SHALL be granted only when LdReq=0 or the starvation rule fires.
REQ-027 Starvation counter (2 bits): increments on each grant to the priority side while the other side requests, clears on any grant to the non-priority side or when the other side is not requesting; at value 3 the next arbitration SHALL grant the non-priority side.
REQ-028 Loader write in Mode=0: grant SHALL be replaced by a one-cycle LdErr pulse in IDLE, no RAM access, no LdAck, LdAddr unchanged, starvation counter unchanged.
REQ-029 ISSUE: RamAddr = CpuAddr or LdAddr, sampled into a register at grant and held through CAP; RamData = write data likewise held; RamWren=1 in ISSUE only, for writes.
REQ-030 CAP: for reads RdData SHALL load RamQ; for writes RdData SHALL be unchanged; CpuAck or LdAck SHALL pulse for exactly this cycle.
REQ-031 Request handshake: requester holds Req and qualifiers until Ack, deasserts next cycle; Req dropped before grant = withdrawn, no access; Req still high in the cycle after Ack = new request.
REQ-032 LdAddr SHALL increment by 1 in LD_CAP, wrapping 15 to 0.
REQ-033 ClearAddGen=1 SHALL set LdAddr to 0 next edge, overriding a same-cycle increment; an in-flight loader access SHALL keep its registered address.
REQ-034 In IDLE, RamAddr, RamData and RamWren SHALL be 0.

Reset
REQ-035 Start=0 SHALL immediately force state IDLE, RamAddr=0, RamData=0, RamWren=0, RdData=0, CpuAck=0, LdAck=0, LdErr=0, LdAddr=0, Busy=0, starvation counter=0.
REQ-036 Reset mid-access SHALL abort the access with no Ack pulse; first grant possible on the first rising edge after Start returns high.

Verification
REQ-037 Mode=0, CpuReq read CpuAddr=5, RamQ=0x3A -> RamWren stays 0, RamAddr=5 for 2 cycles, CpuAck pulse in cycle 2, RdData=0x3A.
REQ-038 Mode=1, ClearAddGen pulse, 16 loader writes 0x10..0x1F -> RamWren 16 pulses at addresses 0..15, LdAddr wraps to 0, 16 LdAck pulses.
REQ-039 Mode=1, LdReq and CpuReq both held continuously -> grant order Ld, Ld, Ld, Cpu, repeating.
REQ-040 Mode=0, LdReq write with CpuReq=0 -> single LdErr pulse, RamWren stays 0, LdAddr unchanged, no LdAck.
REQ-041 Start driven low during CPU_ISSUE of a write -> RamWren falls without a clock edge, no CpuAck, all outputs 0.

Source files
------------

// File: rtl/trisc_ram_arbiter_if.sv
// Bus bundle between the two requesters (CPU, loader), the shared RAM and the arbiter.
// The master side drives requests and RAM read data; the slave side is the arbiter.
interface trisc_ram_arbiter_if;
  logic       Mode;
  logic       ClearAddGen;
  logic       CpuReq;
  logic       CpuWe;
  logic [3:0] CpuAddr;
  logic [7:0] CpuWData;
  logic       LdReq;
  logic       LdWe;
  logic [7:0] LdWData;
  logic [7:0] RamQ;
  logic [3:0] RamAddr;
  logic [7:0] RamData;
  logic       RamWren;
  logic [7:0] RdData;
  logic       CpuAck;
  logic       LdAck;
  logic       LdErr;
  logic [3:0] LdAddr;
  logic       Busy;

  modport master (
    output Mode, ClearAddGen, CpuReq, CpuWe, CpuAddr, CpuWData,
    output LdReq, LdWe, LdWData, RamQ,
    input  RamAddr, RamData, RamWren, RdData, CpuAck, LdAck, LdErr, LdAddr, Busy
  );

  modport slave (
    input  Mode, ClearAddGen, CpuReq, CpuWe, CpuAddr, CpuWData,
    input  LdReq, LdWe, LdWData, RamQ,
    output RamAddr, RamData, RamWren, RdData, CpuAck, LdAck, LdErr, LdAddr, Busy
  );
endinterface

// File: rtl/trisc_ram_arbiter.sv
// Two-requester single-port RAM arbiter: every access is ISSUE then CAP, with a
// 2-bit starvation counter that hands every fourth contested grant to the losing side.
module trisc_ram_arbiter (
  input  logic               SysClock,
  input  logic               Start,
  trisc_ram_arbiter_if.slave arb_io
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CPU_ISSUE = 3'd1;
  localparam logic [2:0] CPU_CAP   = 3'd2;
  localparam logic [2:0] LD_ISSUE  = 3'd3;
  localparam logic [2:0] LD_CAP    = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [7:0] rd_q, rd_d;
  logic [3:0] ld_addr_q, ld_addr_d;
  logic [1:0] starv_q, starv_d;

  logic pri_req, oth_req, grant_pri, grant_oth, grant_cpu, grant_ld, ld_reject;
  logic idle;

  // Priority side follows Mode; the other side wins when the priority side is quiet
  // or once it has been passed over three times in a row.
  always_comb begin
    pri_req   = arb_io.Mode ? arb_io.LdReq  : arb_io.CpuReq;
    oth_req   = arb_io.Mode ? arb_io.CpuReq : arb_io.LdReq;
    grant_oth = oth_req && (!pri_req || (starv_q == 2'd3));
    grant_pri = pri_req && !grant_oth;
    grant_ld  = arb_io.Mode ? grant_pri : grant_oth;
    grant_cpu = arb_io.Mode ? grant_oth : grant_pri;
    ld_reject = grant_ld && !arb_io.Mode && arb_io.LdWe;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rd_d      = rd_q;
    starv_d   = starv_q;
    ld_addr_d = ld_addr_q;
    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          state_d = CPU_ISSUE;
          addr_d  = arb_io.CpuAddr;
          wdata_d = arb_io.CpuWData;
          we_d    = arb_io.CpuWe;
        end else if (grant_ld && !ld_reject) begin
          state_d = LD_ISSUE;
          addr_d  = ld_addr_q;
          wdata_d = arb_io.LdWData;
          we_d    = arb_io.LdWe;
        end
        // A rejected loader write leaves the fairness history untouched.
        if (!ld_reject) begin
          if (grant_oth || !oth_req)
            starv_d = 2'd0;
          else if (grant_pri)
            starv_d = starv_q + 2'd1;
        end
      end
      CPU_ISSUE: state_d = CPU_CAP;
      LD_ISSUE:  state_d = LD_CAP;
      CPU_CAP, LD_CAP: begin
        state_d = IDLE;
        if (!we_q)
          rd_d = arb_io.RamQ;
      end
      default: state_d = IDLE;
    endcase
    if (arb_io.ClearAddGen)
      ld_addr_d = 4'd0;
    else if (state_q == LD_CAP)
      ld_addr_d = ld_addr_q + 4'd1;
  end

  always_ff @(posedge SysClock or negedge Start) begin
    if (!Start) begin
      state_q   <= IDLE;
      addr_q    <= 4'd0;
      wdata_q   <= 8'd0;
      we_q      <= 1'b0;
      rd_q      <= 8'd0;
      ld_addr_q <= 4'd0;
      starv_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      ld_addr_q <= ld_addr_d;
      starv_q   <= starv_d;
    end
  end

  assign idle           = (state_q == IDLE);
  assign arb_io.RamAddr = idle ? 4'd0 : addr_q;
  assign arb_io.RamData = idle ? 8'd0 : wdata_q;
  assign arb_io.RamWren = ((state_q == CPU_ISSUE) || (state_q == LD_ISSUE)) && we_q;
  assign arb_io.RdData  = rd_q;
  assign arb_io.CpuAck  = (state_q == CPU_CAP);
  assign arb_io.LdAck   = (state_q == LD_CAP);
  // LdErr is decoded from live inputs, so it is gated by reset to stay low while Start is low.
  assign arb_io.LdErr   = idle && ld_reject && Start;
  assign arb_io.LdAddr  = ld_addr_q;
  assign arb_io.Busy    = !idle;
endmodule

// File: tb/tb_trisc_ram_arbiter.sv
// Randomized and directed bench for trisc_ram_arbiter against a transaction-level
// model of arbitration, access timing and RAM contents.
module tb_trisc_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trisc_ram_arbiter_if bus();
  trisc_ram_arbiter dut (.SysClock(clk), .Start(rst_n), .arb_io(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Synchronous RAM: read data appears one cycle after the address.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (bus.RamWren) begin
      mem[bus.RamAddr] <= bus.RamData;
    end
    bus.RamQ <= mem[bus.RamAddr];
  end

  logic [28:0] obs;
  assign obs = {bus.Busy, bus.RamWren, bus.RamAddr, bus.RamData, bus.CpuAck,
                bus.LdAck, bus.LdErr, bus.RdData, bus.LdAddr};

  // Reference model: where an access is in its two-cycle life, who owns it, and what RAM holds.
  int         m_phase;
  bit         m_is_ld;
  logic [3:0] m_addr;
  logic [7:0] m_data;
  bit         m_we;
  logic [7:0] m_rd;
  logic [3:0] m_ldaddr;
  int         m_starv;
  logic [7:0] m_mem [16];

  int         cnt_wren, cnt_cpuack, cnt_ldack, cnt_err, cnt_watch;
  logic [3:0] last_wren_addr;
  logic [3:0] watch_addr;
  bit         seen_cpu_ack, seen_ld_ack, seen_ld_err;

  task automatic model_reset();
    m_phase  = 0;
    m_is_ld  = 0;
    m_addr   = 4'd0;
    m_data   = 8'd0;
    m_we     = 0;
    m_rd     = 8'd0;
    m_ldaddr = 4'd0;
    m_starv  = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
  endtask

  // Called at posedge+1 with this cycle's inputs applied; checks, advances, returns at next posedge+1.
  task automatic cycle();
    logic [28:0] e;
    bit cpu_turn, ld_turn, reject, other_req, pri_won;
    #1;
    cpu_turn = 0;
    ld_turn  = 0;
    reject   = 0;
    if (m_phase == 0) begin
      if (bus.CpuReq && bus.LdReq) begin
        if (m_starv == 3) begin
          if (bus.Mode) cpu_turn = 1; else ld_turn = 1;
        end else begin
          if (bus.Mode) ld_turn = 1; else cpu_turn = 1;
        end
      end else begin
        cpu_turn = bus.CpuReq;
        ld_turn  = bus.LdReq;
      end
      reject = ld_turn && !bus.Mode && bus.LdWe;
    end
    e = {m_phase != 0, (m_phase == 1) && m_we, (m_phase == 0) ? 4'd0 : m_addr,
         (m_phase == 0) ? 8'd0 : m_data, (m_phase == 2) && !m_is_ld, (m_phase == 2) && m_is_ld,
         reject, m_rd, m_ldaddr};
    check("outs", 64'(obs), 64'(e));

    seen_cpu_ack = bus.CpuAck;
    seen_ld_ack  = bus.LdAck;
    seen_ld_err  = bus.LdErr;
    if (bus.RamWren) begin
      cnt_wren++;
      last_wren_addr = bus.RamAddr;
    end
    if (bus.CpuAck) cnt_cpuack++;
    if (bus.LdAck) cnt_ldack++;
    if (bus.LdErr) cnt_err++;
    if (bus.Busy && bus.RamAddr == watch_addr) cnt_watch++;

    if (m_phase == 0) begin
      if (!reject) begin
        other_req = bus.Mode ? bus.CpuReq : bus.LdReq;
        pri_won   = bus.Mode ? ld_turn : cpu_turn;
        if (pri_won && other_req) m_starv++; else m_starv = 0;
      end
      if (cpu_turn) begin
        m_phase = 1; m_is_ld = 0; m_addr = bus.CpuAddr; m_data = bus.CpuWData; m_we = bus.CpuWe;
      end else if (ld_turn && !reject) begin
        m_phase = 1; m_is_ld = 1; m_addr = m_ldaddr; m_data = bus.LdWData; m_we = bus.LdWe;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase = 0;
      if (m_we) m_mem[m_addr] = m_data; else m_rd = m_mem[m_addr];
      if (m_is_ld) m_ldaddr = m_ldaddr + 4'd1;
    end
    if (bus.ClearAddGen) m_ldaddr = 4'd0;

    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_wren = 0; cnt_cpuack = 0; cnt_ldack = 0; cnt_err = 0; cnt_watch = 0;
  endtask

  task automatic do_cpu(input logic we, input logic [3:0] a, input logic [7:0] d, output bit done);
    bus.CpuReq = 1'b1; bus.CpuWe = we; bus.CpuAddr = a; bus.CpuWData = d;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      cycle();
      done = seen_cpu_ack;
    end
    bus.CpuReq = 1'b0;
    cycle();
  endtask

  task automatic do_ld(input logic we, input logic [7:0] d, output bit done);
    bus.LdReq = 1'b1; bus.LdWe = we; bus.LdWData = d;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      cycle();
      done = seen_ld_ack || seen_ld_err;
    end
    bus.LdReq = 1'b0;
    cycle();
  endtask

  initial begin
    bit done, cpu_drop, ld_drop, wren_seen;
    int grants;
    bus.Mode = 0; bus.ClearAddGen = 0;
    bus.CpuReq = 0; bus.CpuWe = 0; bus.CpuAddr = 0; bus.CpuWData = 0;
    bus.LdReq = 0; bus.LdWe = 0; bus.LdWData = 0;
    watch_addr = 4'd0; last_wren_addr = 4'd0;
    clear_counts();
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset", 64'(obs), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // CPU read of address 5 after writing 0x3A there.
    bus.Mode = 0;
    do_cpu(1'b1, 4'd5, 8'h3A, done);
    check("r37_wr_ack", 64'(done), 64'd1);
    clear_counts();
    watch_addr = 4'd5;
    do_cpu(1'b0, 4'd5, 8'h00, done);
    check("r37_ack", 64'(cnt_cpuack), 64'd1);
    check("r37_wren", 64'(cnt_wren), 64'd0);
    check("r37_addr_cycles", 64'(cnt_watch), 64'd2);
    check("r37_rd", 64'(bus.RdData), 64'h3A);

    // Loader block write 0x10..0x1F after an address clear.
    bus.Mode = 1;
    bus.ClearAddGen = 1;
    cycle();
    bus.ClearAddGen = 0;
    check("r38_clr", 64'(bus.LdAddr), 64'd0);
    clear_counts();
    for (int k = 0; k < 16; k++) begin
      do_ld(1'b1, 8'(8'h10 + k), done);
      check($sformatf("r38_addr%0d", k), 64'(last_wren_addr), 64'(k));
    end
    check("r38_wren", 64'(cnt_wren), 64'd16);
    check("r38_acks", 64'(cnt_ldack), 64'd16);
    check("r38_wrap", 64'(bus.LdAddr), 64'd0);

    // Both held continuously in load mode: Ld, Ld, Ld, Cpu repeating.
    bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 4'd3;
    bus.LdReq = 1; bus.LdWe = 0;
    grants = 0;
    for (int n = 0; n < 40 && grants < 8; n++) begin
      cycle();
      if (seen_cpu_ack || seen_ld_ack) begin
        check($sformatf("r39_grant%0d", grants), 64'(seen_ld_ack), 64'((grants % 4) != 3));
        grants++;
      end
    end
    check("r39_count", 64'(grants), 64'd8);
    bus.CpuReq = 0; bus.LdReq = 0;
    cycle();
    cycle();

    // Loader write in run mode is rejected.
    bus.Mode = 0;
    clear_counts();
    do_ld(1'b1, 8'h99, done);
    cycle();
    cycle();
    check("r40_err", 64'(cnt_err), 64'd1);
    check("r40_ldack", 64'(cnt_ldack), 64'd0);
    check("r40_wren", 64'(cnt_wren), 64'd0);
    check("r40_ldaddr", 64'(bus.LdAddr), 64'(m_ldaddr));

    // Reset asserted during the ISSUE cycle of a CPU write.
    bus.CpuReq = 1; bus.CpuWe = 1; bus.CpuAddr = 4'd9; bus.CpuWData = 8'h77;
    wren_seen = 0;
    for (int n = 0; n < 10 && !wren_seen; n++) begin
      cycle();
      wren_seen = bus.RamWren;
    end
    check("r41_issue", 64'(wren_seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r41_async", 64'(obs), 64'd0);
    bus.CpuReq = 0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("r41_held", 64'(obs), 64'd0);
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle();
    check("r41_noack", 64'(cnt_cpuack), 64'd0);

    // Randomized traffic with mode flips, address clears and occasional withdrawals.
    cpu_drop = 0;
    ld_drop  = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) bus.Mode = ~bus.Mode;
      bus.ClearAddGen = ($urandom_range(0, 31) == 0);
      if (cpu_drop) begin
        bus.CpuReq = 0; cpu_drop = 0;
      end else if (!bus.CpuReq) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.CpuReq = 1; bus.CpuWe = 1'($urandom); bus.CpuAddr = 4'($urandom); bus.CpuWData = 8'($urandom);
        end
      end else if (!bus.Busy && $urandom_range(0, 99) == 0) begin
        bus.CpuReq = 0;
      end
      if (ld_drop) begin
        bus.LdReq = 0; ld_drop = 0;
      end else if (!bus.LdReq) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.LdReq = 1; bus.LdWe = 1'($urandom); bus.LdWData = 8'($urandom);
        end
      end else if (!bus.Busy && $urandom_range(0, 99) == 0) begin
        bus.LdReq = 0;
      end
      cycle();
      if (seen_cpu_ack) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.CpuWe = 1'($urandom); bus.CpuAddr = 4'($urandom); bus.CpuWData = 8'($urandom);
        end else begin
          cpu_drop = 1;
        end
      end
      if (seen_ld_ack || seen_ld_err) begin
        if (seen_ld_ack && $urandom_range(0, 3) == 0) begin
          bus.LdWe = 1'($urandom); bus.LdWData = 8'($urandom);
        end else begin
          ld_drop = 1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
